// File: rtl/bkg_calib_controller.sv
// bkg_calib_controller
// Purpose : builds the pedestal (background) table for the reconstruction
//           datapath. It taps the sensor Avalon-ST frame stream and averages
//           2^L beam-off frames per channel. It then writes one rounded,
//           saturated average per channel into the background table RAM.
//           While the table is being rebuilt, reconstruction is held in bypass.
// Ports   : clk_clk / rst_reset                      clock, async active-high reset
//           data_in_*                                 Avalon-ST sink (never backpressures)
//           ctrl_start / ctrl_frames_log2             rising-edge start, requested L
//           bkg_wr_en / bkg_wr_address / bkg_wr_data  table write port
//           bypass_bkg                                reconstruction skips subtraction
//           status_busy / status_done / status_error  run status (done/error sticky)
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a start edge; all stream beats are discarded
// WAIT_SOP | run active; discarding beats until a start-of-packet
// ACCUM    | inside a frame; accumulating channel pairs, checking framing
// WRITE    | sweeping channels 0..NUM_CHANNELS-1 into the table, one per cycle
module bkg_calib_controller #(
    parameter int WORDS_PER_FRAME = 163,
    parameter int HEADER_WORDS    = 3,
    parameter int NUM_CHANNELS    = 320,
    parameter int MAX_LOG2        = 8,
    parameter int ACC_WIDTH       = 24
) (
    input  logic        clk_clk,
    input  logic        rst_reset,
    input  logic [31:0] data_in_data,
    input  logic        data_in_valid,
    output logic        data_in_ready,
    input  logic        data_in_startofpacket,
    input  logic        data_in_endofpacket,
    input  logic        ctrl_start,
    input  logic [3:0]  ctrl_frames_log2,
    output logic        bkg_wr_en,
    output logic [8:0]  bkg_wr_address,
    output logic [15:0] bkg_wr_data,
    output logic        bypass_bkg,
    output logic        status_busy,
    output logic        status_done,
    output logic        status_error
);

    localparam int         PAIRS   = WORDS_PER_FRAME - HEADER_WORDS;
    localparam logic [7:0] LAST_K  = 8'(WORDS_PER_FRAME - 1);
    localparam logic [7:0] HDR_K   = 8'(HEADER_WORDS);
    localparam logic [8:0] LAST_CH = 9'(NUM_CHANNELS - 1);
    localparam logic [3:0] MAX_L   = 4'(MAX_LOG2);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_SOP = 2'd1;
    localparam logic [1:0] S_ACCUM    = 2'd2;
    localparam logic [1:0] S_WRITE    = 2'd3;

    logic [1:0] state_q, state_d;
    logic       start_prev_q, start_prev_d;
    logic       ready_q, ready_d;
    logic [3:0] l_q, l_d;
    logic [8:0] frame_ctr_q, frame_ctr_d;
    logic [7:0] word_ctr_q, word_ctr_d;
    logic [8:0] ch_q, ch_d;
    logic       done_q, done_d;
    logic       error_q, error_d;

    logic [ACC_WIDTH-1:0] acc_hi_q [PAIRS];
    logic [ACC_WIDTH-1:0] acc_lo_q [PAIRS];

    logic                 start_pulse;
    logic                 process_beat;
    logic [7:0]           beat_k;
    logic                 beat_err;
    logic                 frame_end;
    logic                 acc_we;
    logic [7:0]           acc_j;
    logic [8:0]           frame_ctr_inc;
    logic [8:0]           frames_target;
    logic [7:0]           rd_j;
    logic [ACC_WIDTH-1:0] rd_val;
    logic [ACC_WIDTH:0]   rnd;
    logic [ACC_WIDTH:0]   sum;
    logic [ACC_WIDTH:0]   shifted;
    logic [15:0]          avg_sat;

    assign start_pulse = ctrl_start & ~start_prev_q;

    // An SOP beat seen in WAIT_SOP is word 0 of the frame, whatever word_ctr holds.
    assign beat_k       = (state_q == S_ACCUM) ? word_ctr_q : 8'd0;
    assign process_beat = data_in_valid & ready_q &
                          ((state_q == S_ACCUM) |
                           ((state_q == S_WAIT_SOP) & data_in_startofpacket));

    // The counter never passes LAST_K, so "EOP not on the last word" covers early EOP.
    assign beat_err  = process_beat &
                       ((data_in_startofpacket & (beat_k != 8'd0)) |
                        (data_in_endofpacket   & (beat_k != LAST_K)) |
                        (~data_in_endofpacket  & (beat_k == LAST_K)));
    assign frame_end = process_beat & ~beat_err & data_in_endofpacket;
    assign acc_we    = process_beat & ~beat_err & (beat_k >= HDR_K);
    assign acc_j     = beat_k - HDR_K;

    assign frame_ctr_inc = frame_ctr_q + 9'd1;
    assign frames_target = 9'd1 << l_q;

    always_comb begin
        state_d      = state_q;
        start_prev_d = ctrl_start;
        ready_d      = 1'b1;
        l_d          = l_q;
        frame_ctr_d  = frame_ctr_q;
        word_ctr_d   = word_ctr_q;
        ch_d         = ch_q;
        done_d       = done_q;
        error_d      = error_q;
        case (state_q)
            S_IDLE: begin
                if (start_pulse) begin
                    l_d         = (ctrl_frames_log2 > MAX_L) ? MAX_L : ctrl_frames_log2;
                    frame_ctr_d = 9'd0;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    state_d     = S_WAIT_SOP;
                end
            end
            S_WAIT_SOP, S_ACCUM: begin
                if (beat_err) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else if (frame_end) begin
                    frame_ctr_d = frame_ctr_inc;
                    word_ctr_d  = 8'd0;
                    if (frame_ctr_inc == frames_target) begin
                        ch_d    = 9'd0;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_WAIT_SOP;
                    end
                end else if (process_beat) begin
                    word_ctr_d = beat_k + 8'd1;
                    state_d    = S_ACCUM;
                end
            end
            default: begin
                if (ch_q == LAST_CH) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    ch_d = ch_q + 9'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_clk or posedge rst_reset) begin
        if (rst_reset) begin
            state_q      <= S_IDLE;
            start_prev_q <= 1'b0;
            ready_q      <= 1'b0;
            l_q          <= 4'd0;
            frame_ctr_q  <= 9'd0;
            word_ctr_q   <= 8'd0;
            ch_q         <= 9'd0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            ready_q      <= ready_d;
            l_q          <= l_d;
            frame_ctr_q  <= frame_ctr_d;
            word_ctr_q   <= word_ctr_d;
            ch_q         <= ch_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    // Accumulator RAM: the first frame overwrites, so no clear pass is needed
    // between runs and the contents need no reset.
    always_ff @(posedge clk_clk) begin
        if (acc_we) begin
            if (frame_ctr_q == 9'd0) begin
                acc_hi_q[acc_j] <= ACC_WIDTH'(data_in_data[31:16]);
                acc_lo_q[acc_j] <= ACC_WIDTH'(data_in_data[15:0]);
            end else begin
                acc_hi_q[acc_j] <= acc_hi_q[acc_j] + ACC_WIDTH'(data_in_data[31:16]);
                acc_lo_q[acc_j] <= acc_lo_q[acc_j] + ACC_WIDTH'(data_in_data[15:0]);
            end
        end
    end

    // Even channels come from the high half-word and odd channels from the low half-word.
    assign rd_j    = ch_q[8:1];
    assign rd_val  = ch_q[0] ? acc_lo_q[rd_j] : acc_hi_q[rd_j];
    assign rnd     = (l_q == 4'd0) ? '0 : ((ACC_WIDTH+1)'(1) << (l_q - 4'd1));
    assign sum     = {1'b0, rd_val} + rnd;
    assign shifted = sum >> l_q;
    assign avg_sat = (|shifted[ACC_WIDTH:16]) ? 16'hFFFF : shifted[15:0];

    assign bkg_wr_en      = (state_q == S_WRITE);
    assign bkg_wr_address = bkg_wr_en ? ch_q : 9'd0;
    assign bkg_wr_data    = bkg_wr_en ? avg_sat : 16'd0;
    assign bypass_bkg     = (state_q != S_IDLE);
    assign status_busy    = (state_q != S_IDLE);
    assign status_done    = done_q;
    assign status_error   = error_q;
    assign data_in_ready  = ready_q;

endmodule

// File: tb/tb_bkg_calib_controller.sv
module tb_bkg_calib_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] din = '0;
    logic        vld = 1'b0, sop = 1'b0, eop = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  flog = '0;
    logic        ready, wr_en, bypass, busy, done, err;
    logic [8:0]  addr;
    logic [15:0] wdata;

    bkg_calib_controller dut (
        .clk_clk(clk), .rst_reset(rst),
        .data_in_data(din), .data_in_valid(vld), .data_in_ready(ready),
        .data_in_startofpacket(sop), .data_in_endofpacket(eop),
        .ctrl_start(start), .ctrl_frames_log2(flog),
        .bkg_wr_en(wr_en), .bkg_wr_address(addr), .bkg_wr_data(wdata),
        .bypass_bkg(bypass), .status_busy(busy),
        .status_done(done), .status_error(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Write-port monitor: samples on the falling edge, away from the active edge.
    int wr_count = 0, addr_err = 0, bypass_low = 0;
    int neg_cyc = 0, last_eop_neg = 0, first_wr_neg = -1;
    int got [320];

    always @(negedge clk) begin
        neg_cyc++;
        if (vld && ready && eop) last_eop_neg = neg_cyc;
        if (wr_en) begin
            if (wr_count == 0) first_wr_neg = neg_cyc;
            if (int'(addr) != wr_count) addr_err++;
            if (addr < 9'd320) got[addr] = int'(wdata);
            if (!bypass) bypass_low++;
            wr_count++;
        end
    end

    task automatic beat(input logic [31:0] d, input logic s, input logic e);
        @(posedge clk); #1;
        din = d; sop = s; eop = e; vld = 1'b1;
    endtask

    task automatic idle_cyc();
        @(posedge clk); #1;
        vld = 1'b0; sop = 1'b0; eop = 1'b0;
    endtask

    task automatic pulse_start(input int lreq);
        @(posedge clk); #1;
        vld = 1'b0; sop = 1'b0; eop = 1'b0;
        flog = 4'(lreq); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic clear_mon();
        wr_count = 0; addr_err = 0; bypass_low = 0; first_wr_neg = -1;
        for (int c = 0; c < 320; c++) got[c] = -1;
    endtask

    // mode 0: constant 0x0010_0020, 1: random, 2: all ones, 3: random with ch0 = 1,2,3,5
    task automatic run_cal(input int lreq, input int mode, input bit junk, input bit midstart);
        int     l_eff, nf, r, lat;
        longint sums [320];
        longint expv;
        logic [15:0] hi, lo;
        int ch0v [4];
        ch0v = '{1, 2, 3, 5};
        l_eff = (lreq > 8) ? 8 : lreq;
        nf    = 1 << l_eff;
        for (int c = 0; c < 320; c++) sums[c] = 0;
        clear_mon();
        pulse_start(lreq);
        @(negedge clk);
        chk("busy_on", busy, 1);
        chk("bypass_on", bypass, 1);
        chk("done_cleared", done, 0);
        chk("error_cleared", err, 0);
        for (int f = 0; f < nf; f++) begin
            if (junk) for (int i = 0; i < 3; i++) beat($urandom, 1'b0, 1'($urandom_range(0, 1)));
            for (int w = 0; w < 163; w++) begin
                case (mode)
                    0: begin hi = 16'h0010; lo = 16'h0020; end
                    2: begin hi = 16'hFFFF; lo = 16'hFFFF; end
                    default: begin hi = 16'($urandom); lo = 16'($urandom); end
                endcase
                if (mode == 3 && w == 3) hi = 16'(ch0v[f]);
                if (w >= 3) begin
                    sums[2*(w-3)]   += longint'(hi);
                    sums[2*(w-3)+1] += longint'(lo);
                end
                beat({hi, lo}, w == 0, w == 162);
                if (midstart && f == 0 && w == 50) begin start = 1'b1; flog = 4'd0; end
                if (midstart && f == 0 && w == 60) start = 1'b0;
                if (nf <= 8 && $urandom_range(0, 7) == 0) idle_cyc();
            end
        end
        idle_cyc();
        for (int i = 0; i < 1000 && !(done || err); i++) @(negedge clk);
        @(negedge clk);
        chk("done_set", done, 1);
        chk("error_clear", err, 0);
        chk("busy_off", busy, 0);
        chk("bypass_off", bypass, 0);
        chk("write_count", wr_count, 320);
        chk("addr_order_errs", addr_err, 0);
        chk("bypass_low_during_write", bypass_low, 0);
        lat = first_wr_neg - last_eop_neg;
        chk("write_latency_1to2", (lat >= 1 && lat <= 2) ? 1 : 0, 1);
        r = (l_eff == 0) ? 0 : (1 << (l_eff - 1));
        for (int c = 0; c < 320; c++) begin
            expv = (sums[c] + r) >> l_eff;
            if (expv > 65535) expv = 65535;
            chk($sformatf("data[%0d]", c), got[c], expv);
        end
        if (mode == 3) chk("ch0_avg", got[0], 3);
        if (mode == 0) begin
            chk("addr0_const", got[0], 16);
            chk("addr1_const", got[1], 32);
        end
    endtask

    // kind 0: EOP on word 100 of frame 2; 1: no EOP on word 162; 2: SOP on word 50
    task automatic run_err(input int kind);
        bit stop;
        logic s, e;
        stop = 1'b0;
        clear_mon();
        pulse_start(2);
        for (int f = 0; f < 4 && !stop; f++) begin
            for (int w = 0; w < 163 && !stop; w++) begin
                s = (w == 0); e = (w == 162);
                if (kind == 0 && f == 2 && w == 100) begin e = 1'b1; stop = 1'b1; end
                if (kind == 1 && f == 0 && w == 162) begin e = 1'b0; stop = 1'b1; end
                if (kind == 2 && f == 1 && w == 50)  begin s = 1'b1; stop = 1'b1; end
                beat($urandom, s, e);
            end
        end
        idle_cyc();
        repeat (3) @(negedge clk);
        chk($sformatf("err%0d_error", kind), err, 1);
        chk($sformatf("err%0d_busy", kind), busy, 0);
        chk($sformatf("err%0d_bypass", kind), bypass, 0);
        chk($sformatf("err%0d_done", kind), done, 0);
        chk($sformatf("err%0d_writes", kind), wr_count, 0);
    endtask

    initial begin
        int snap;
        #2;
        chk("rst_ready", ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bypass", bypass, 0);
        chk("rst_done", done, 0);
        chk("rst_error", err, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", ready, 1);

        run_cal(0, 0, 1'b0, 1'b0);
        run_cal(2, 3, 1'b0, 1'b0);
        run_err(0);
        run_cal(1, 1, 1'b0, 1'b0);
        run_err(1);
        run_err(2);
        run_cal(3, 1, 1'b1, 1'b1);
        run_cal(12, 2, 1'b0, 1'b0);

        // Reset in the middle of a write sweep.
        clear_mon();
        pulse_start(1);
        for (int f = 0; f < 2; f++)
            for (int w = 0; w < 163; w++) beat($urandom, w == 0, w == 162);
        idle_cyc();
        for (int i = 0; i < 1000 && wr_count < 150; i++) @(negedge clk);
        #1;
        chk("wr_en_before_rst", wr_en, 1);
        rst = 1'b1;
        #1;
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_bypass", bypass, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_ready", ready, 0);
        snap = wr_count;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_midrst", ready, 1);
        repeat (5) @(negedge clk);
        chk("no_writes_after_rst", wr_count, snap);
        chk("done_after_midrst", done, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bkg_calib_controller.md
Name: bkg_calib_controller

Overview:
- Sequences pedestal (background) calibration for the reconstruction datapath.
- Taps the sensor-interface Avalon-ST frame stream and averages 2^L beam-off frames per channel.
- Writes the 320 per-channel averages into the background table RAM that the reconstruction block subtracts from.
- Holds the reconstruction block in bypass (no subtraction) while the table is being rebuilt.

Parameters:
- WORDS_PER_FRAME, 163: beats per frame, header included.
- HEADER_WORDS, 3: leading header beats, ignored.
- NUM_CHANNELS, 320: 2 × (WORDS_PER_FRAME − HEADER_WORDS).
- MAX_LOG2, 8: largest accepted frames_log2.
- ACC_WIDTH, 24: per-channel accumulator width; must be at least 16 + MAX_LOG2.

Ports:
- clk_clk, in, 1: single clock.
- rst_reset, in, 1: asynchronous, active-high reset.
- data_in_data, in, 32: frame beat; [31:16] is the even channel, [15:0] the odd channel.
- data_in_valid, in, 1: beat valid.
- data_in_ready, out, 1: sink ready.
- data_in_startofpacket, in, 1: first beat of frame.
- data_in_endofpacket, in, 1: last beat of frame.
- ctrl_start, in, 1: rising-edge start request.
- ctrl_frames_log2, in, 4: L; sampled on start.
- bkg_wr_en, out, 1: table write strobe.
- bkg_wr_address, out, 9: channel index 0..319.
- bkg_wr_data, out, 16: background value.
- bypass_bkg, out, 1: tells reconstruction to skip subtraction.
- status_busy, out, 1: calibration in progress.
- status_done, out, 1: sticky; table written successfully.
- status_error, out, 1: sticky; malformed frame aborted the run.

Behaviour:
- Reset (async, any state):
  - state = IDLE.
  - All outputs 0, including data_in_ready, status_done and status_error.
  - Any write sweep stops immediately; the table is left partial.
  - Accumulator contents are don't-care.
- data_in_ready is 1 in every state once reset is released; the block never backpressures.
  - Beats are accepted when valid & ready.
  - Beats accepted outside WAIT_SOP/ACCUM are discarded.
- Start detection:
  - Start = ctrl_start high this cycle and low the previous cycle.
  - Start is honoured only in IDLE; it is ignored while busy.
- On start:
  - L = min(ctrl_frames_log2, MAX_LOG2) is latched.
  - frame_ctr = 0; status_done and status_error are cleared.
  - bypass_bkg and status_busy go to 1 on the next cycle.
  - state → WAIT_SOP.
- WAIT_SOP:
  - Beats without SOP are discarded.
  - A beat with SOP sets word_ctr = 0, is treated as word 0, and moves state → ACCUM.
- ACCUM, per accepted beat at word index k:
  - k < HEADER_WORDS: ignored.
  - Otherwise j = k − HEADER_WORDS.
  - frame_ctr == 0: acc[2j] = data[31:16] and acc[2j+1] = data[15:0] (overwrite; no clear pass needed).
  - frame_ctr > 0: both values are added to the existing accumulators. Operands are unsigned and zero-extended to ACC_WIDTH.
- Frame completion:
  - The frame is complete when EOP arrives on k = WORDS_PER_FRAME−1.
  - Then frame_ctr increments.
  - If frame_ctr+1 == 2^L, state → WRITE; otherwise state → WAIT_SOP.
- Error conditions:
  - EOP on k < WORDS_PER_FRAME−1.
  - SOP on k > 0.
  - k reaches WORDS_PER_FRAME−1 without EOP.
- On error:
  - status_error = 1, busy = 0, bypass_bkg = 0.
  - state → IDLE; the table is untouched.
- WRITE:
  - One channel per cycle, ch = 0..NUM_CHANNELS−1; bkg_wr_en = 1 for exactly 320 consecutive cycles.
  - bkg_wr_address = ch.
  - bkg_wr_data = sat16((acc[ch] + R) >> L), where R = 2^(L−1) for L > 0 and R = 0 for L = 0.
  - sat16 clamps results above 0xFFFF to 0xFFFF.
  - Write latency from the completing EOP beat to the first write strobe is at most 2 cycles.
- After the last write (next cycle):
  - bkg_wr_en = 0, bypass_bkg = 0, status_busy = 0, status_done = 1.
  - state → IDLE.
- Table layout: address 2j carries the high-half channel of data word j+HEADER_WORDS, and address 2j+1 the low half. This matches the reconstruction subtraction order.
- status_done and status_error stay set until the next honoured start or reset.

Test Plan:
- L=0, one frame with every data word 0x0010_0020, SOP/EOP correct → 320 writes: even addresses 0x0010, odd addresses 0x0020; done=1, error=0, bypass high throughout, then 0.
- L=2, four frames with ch0 = 1, 2, 3, 5 (sum 11) → addr0 = (11+2)>>2 = 3; write starts ≤2 cycles after the 4th EOP; exactly 320 strobes.
- L=8, 256 frames of 0xFFFF on every channel → all data = 0xFFFF, no overflow or wrap; ctrl_frames_log2=12 behaves as L=8 (256 frames).
- EOP on word 100 of frame 2 → error=1, busy=0, zero table writes; next start with good frames → done=1, error=0.
- Junk beats before SOP, and a second start pulse mid-ACCUM → junk ignored, restart ignored, frame count unchanged, correct averages.
- Assert rst_reset at write 150 → same cycle: wr_en=0, bypass=0, busy=0, done=0; ready=1 after release.
